// File: rtl/s_axi_lite_regbank.sv
// ============================================================================
// s_axi_lite_regbank
// ----------------------------------------------------------------------------
// AXI4-Lite slave with a bank of NUM_REGS read/write registers. Each register
// is DATA_WIDTH bits wide and sits on a DATA_WIDTH/8-byte aligned address.
// The write and read channels are handled by two independent state machines,
// so a read and a write can be in progress at the same time.
//
// Parameters
//   NUM_REGS   : number of registers (1..64)
//   DATA_WIDTH : register and data-bus width (32 or 64)
//   ADDR_WIDTH : byte-address width. The word index is
//                ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
//
// Configuration macro
//   S_AXI_LITE_REGBANK_WSTRB_EN : when defined, WSTRB selects which bytes of
//                                 a register are written. When undefined,
//                                 WSTRB is ignored and every accepted
//                                 in-range write replaces the whole word.
//
// Ports
//   S_AXI_ACLK               in   clock, rising edge
//   S_AXI_ARESET             in   asynchronous active-high reset
//   S_AXI_LITE_AW*           write address channel (AWADDR, AWVALID, AWREADY)
//   S_AXI_LITE_W*            write data channel (WDATA, WSTRB, WVALID, WREADY)
//   S_AXI_LITE_B*            write response channel (BRESP, BVALID, BREADY)
//   S_AXI_LITE_AR*           read address channel (ARADDR, ARVALID, ARREADY)
//   S_AXI_LITE_R*            read data channel (RDATA, RRESP, RVALID, RREADY)
//   REGS_OUT                 out  all registers, register i at
//                                 [i*DATA_WIDTH +: DATA_WIDTH]
// ============================================================================
module s_axi_lite_regbank #(
   parameter int NUM_REGS   = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESET,

   input  logic [ADDR_WIDTH-1:0]          S_AXI_LITE_AWADDR,
   input  logic                           S_AXI_LITE_AWVALID,
   output logic                           S_AXI_LITE_AWREADY,

   input  logic [DATA_WIDTH-1:0]          S_AXI_LITE_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_LITE_WSTRB,
   input  logic                           S_AXI_LITE_WVALID,
   output logic                           S_AXI_LITE_WREADY,

   output logic [1:0]                     S_AXI_LITE_BRESP,
   output logic                           S_AXI_LITE_BVALID,
   input  logic                           S_AXI_LITE_BREADY,

   input  logic [ADDR_WIDTH-1:0]          S_AXI_LITE_ARADDR,
   input  logic                           S_AXI_LITE_ARVALID,
   output logic                           S_AXI_LITE_ARREADY,

   output logic [DATA_WIDTH-1:0]          S_AXI_LITE_RDATA,
   output logic [1:0]                     S_AXI_LITE_RRESP,
   output logic                           S_AXI_LITE_RVALID,
   input  logic                           S_AXI_LITE_RREADY,

   output logic [NUM_REGS*DATA_WIDTH-1:0] REGS_OUT
);

   localparam int          STRB_WIDTH = DATA_WIDTH / 8;
   localparam int          ADDR_LSB   = $clog2(STRB_WIDTH);
   localparam int          IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
   localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   w_state_t              w_state;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic [IDX_WIDTH-1:0]  aw_idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   r_state_t              r_state;
   logic                  arready_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic [IDX_WIDTH-1:0]  aw_idx_in;
   logic [IDX_WIDTH-1:0]  rd_idx;
   logic                  rd_ok;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  commit_en;
   logic                  commit_ok;
   logic [IDX_WIDTH-1:0]  commit_idx;
   logic [DATA_WIDTH-1:0] commit_data;

`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [STRB_WIDTH-1:0] commit_strb;

   // Merge the new word into the old one, byte by byte, wherever the strobe
   // bit is set. A zero strobe leaves the register untouched.
   function automatic logic [DATA_WIDTH-1:0] apply_strobe(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [STRB_WIDTH-1:0] strb
   );
      logic [DATA_WIDTH-1:0] result;
      result = old_word;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         if (strb[b]) begin
            result[b*8 +: 8] = new_word[b*8 +: 8];
         end
      end
      return result;
   endfunction
`endif

   // The byte offset within a word carries no meaning for this bank, and in
   // the full-word build neither does the strobe; fold them into one signal
   // so their disuse is explicit.
   logic unused_inputs;
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
   assign unused_inputs = ^{S_AXI_LITE_AWADDR[ADDR_LSB-1:0],
                            S_AXI_LITE_ARADDR[ADDR_LSB-1:0]};
`else
   assign unused_inputs = ^{S_AXI_LITE_AWADDR[ADDR_LSB-1:0],
                            S_AXI_LITE_ARADDR[ADDR_LSB-1:0],
                            S_AXI_LITE_WSTRB};
`endif

   assign aw_hs     = S_AXI_LITE_AWVALID && awready_q;
   assign w_hs      = S_AXI_LITE_WVALID  && wready_q;
   assign ar_hs     = S_AXI_LITE_ARVALID && arready_q;
   assign aw_idx_in = S_AXI_LITE_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
   assign rd_idx    = S_AXI_LITE_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

   // Work out whether this edge completes a write, and if so which address
   // and data it uses. Whichever half arrives on this edge comes straight
   // from the bus; the half that arrived earlier comes from its capture
   // register. This lets the write commit on the very edge of the second
   // handshake instead of one cycle later.
   always_comb begin
      commit_en   = 1'b0;
      commit_idx  = aw_idx_q;
      commit_data = wdata_q;
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
      commit_strb = wstrb_q;
`endif
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit_en   = 1'b1;
               commit_idx  = aw_idx_in;
               commit_data = S_AXI_LITE_WDATA;
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
               commit_strb = S_AXI_LITE_WSTRB;
`endif
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               commit_en   = 1'b1;
               commit_data = S_AXI_LITE_WDATA;
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
               commit_strb = S_AXI_LITE_WSTRB;
`endif
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               commit_en  = 1'b1;
               commit_idx = aw_idx_in;
            end
         end
         default: begin
            commit_en = 1'b0;
         end
      endcase
   end

   assign commit_ok = (32'(commit_idx) < NUM_REGS_U);

   // Write channel state machine. AWREADY and WREADY are registered and only
   // rise once the machine is idle out of reset, so nothing is accepted on
   // the first edge after reset is released. Once both halves of a write
   // have been taken the machine parks in W_RESP with both READYs low until
   // the master accepts the response.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         w_state   <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
         wstrb_q   <= '0;
`endif
      end else begin
         if (aw_hs) begin
            aw_idx_q <= aw_idx_in;
         end
         if (w_hs) begin
            wdata_q <= S_AXI_LITE_WDATA;
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
            wstrb_q <= S_AXI_LITE_WSTRB;
`endif
         end

         case (w_state)
            W_IDLE: begin
               awready_q <= 1'b1;
               wready_q  <= 1'b1;
               if (commit_en) begin
                  w_state   <= W_RESP;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
               end else if (aw_hs) begin
                  w_state   <= W_HAVE_AW;
                  awready_q <= 1'b0;
               end else if (w_hs) begin
                  w_state   <= W_HAVE_W;
                  wready_q  <= 1'b0;
               end
            end
            W_HAVE_AW: begin
               if (commit_en) begin
                  w_state  <= W_RESP;
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_HAVE_W: begin
               if (commit_en) begin
                  w_state   <= W_RESP;
                  awready_q <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (S_AXI_LITE_BREADY) begin
                  w_state   <= W_IDLE;
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            default: begin
               w_state <= W_IDLE;
            end
         endcase
      end
   end

   // Register storage. An out-of-range write still completes on the bus but
   // touches nothing here. The index is compared against each register
   // number rather than used as an array subscript so that addresses past
   // the end of the bank can never alias onto a real register.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (commit_en && commit_ok) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_idx == IDX_WIDTH'(i)) begin
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
               regs[i] <= apply_strobe(regs[i], commit_data, commit_strb);
`else
               regs[i] <= commit_data;
`endif
            end
         end
      end
   end

   // Read-side register select. Out-of-range indices fall through to zero.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_WIDTH'(i)) begin
            rd_word = regs[i];
         end
      end
   end

   assign rd_ok = (32'(rd_idx) < NUM_REGS_U);

   // Read channel state machine. The register value is sampled on the AR
   // handshake edge, so a write committing to the same register on that
   // edge is not yet visible and the old contents are returned. RDATA and
   // RRESP then hold until the master takes them.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  r_state   <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rd_ok ? rd_word : '0;
                  rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_DATA: begin
               if (S_AXI_LITE_RREADY) begin
                  r_state   <= R_IDLE;
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
               end
            end
            default: begin
               r_state <= R_IDLE;
            end
         endcase
      end
   end

   assign S_AXI_LITE_AWREADY = awready_q;
   assign S_AXI_LITE_WREADY  = wready_q;
   assign S_AXI_LITE_BVALID  = bvalid_q;
   assign S_AXI_LITE_BRESP   = bresp_q;
   assign S_AXI_LITE_ARREADY = arready_q;
   assign S_AXI_LITE_RVALID  = rvalid_q;
   assign S_AXI_LITE_RRESP   = rresp_q;
   assign S_AXI_LITE_RDATA   = rdata_q;

   // Flatten the register array onto the REGS_OUT bus.
   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign REGS_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

endmodule

// File: tb/tb_s_axi_lite_regbank.sv
// ============================================================================
// tb_s_axi_lite_regbank
// ----------------------------------------------------------------------------
// Directed testbench for s_axi_lite_regbank with default parameters
// (8 registers, 32-bit data, 8-bit addresses). A small model array holds the
// register contents the bank should have; REGS_OUT is compared to it after
// every write. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, well away from the next edge.
// ============================================================================
module tb_s_axi_lite_regbank;

   localparam int NUM_REGS   = 8;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 8;

   logic                           clk;
   logic                           rst;
   logic [ADDR_WIDTH-1:0]          awaddr;
   logic                           awvalid;
   logic                           awready;
   logic [DATA_WIDTH-1:0]          wdata;
   logic [DATA_WIDTH/8-1:0]        wstrb;
   logic                           wvalid;
   logic                           wready;
   logic [1:0]                     bresp;
   logic                           bvalid;
   logic                           bready;
   logic [ADDR_WIDTH-1:0]          araddr;
   logic                           arvalid;
   logic                           arready;
   logic [DATA_WIDTH-1:0]          rdata;
   logic [1:0]                     rresp;
   logic                           rvalid;
   logic                           rready;
   logic [NUM_REGS*DATA_WIDTH-1:0] regs_out;

   int          checks;
   int          failures;
   logic [31:0] model [NUM_REGS];

   s_axi_lite_regbank #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .S_AXI_ACLK         (clk),
      .S_AXI_ARESET       (rst),
      .S_AXI_LITE_AWADDR  (awaddr),
      .S_AXI_LITE_AWVALID (awvalid),
      .S_AXI_LITE_AWREADY (awready),
      .S_AXI_LITE_WDATA   (wdata),
      .S_AXI_LITE_WSTRB   (wstrb),
      .S_AXI_LITE_WVALID  (wvalid),
      .S_AXI_LITE_WREADY  (wready),
      .S_AXI_LITE_BRESP   (bresp),
      .S_AXI_LITE_BVALID  (bvalid),
      .S_AXI_LITE_BREADY  (bready),
      .S_AXI_LITE_ARADDR  (araddr),
      .S_AXI_LITE_ARVALID (arvalid),
      .S_AXI_LITE_ARREADY (arready),
      .S_AXI_LITE_RDATA   (rdata),
      .S_AXI_LITE_RRESP   (rresp),
      .S_AXI_LITE_RVALID  (rvalid),
      .S_AXI_LITE_RREADY  (rready),
      .REGS_OUT           (regs_out)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls far beyond any test's length.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish, time=%0t required<200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Flatten the model the same way REGS_OUT is laid out.
   function automatic logic [NUM_REGS*DATA_WIDTH-1:0] packed_model();
      logic [NUM_REGS*DATA_WIDTH-1:0] r;
      for (int i = 0; i < NUM_REGS; i++) begin
         r[i*DATA_WIDTH +: DATA_WIDTH] = model[i];
      end
      return r;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write with AW and W offered together and BREADY high; waits on
   // every handshake with a bounded cycle count.
   task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done;
      bit w_done;
      bit aw_now;
      bit w_now;
      int cnt;
      aw_done = 0;
      w_done  = 0;
      cnt     = 0;
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      while (!(aw_done && w_done) && cnt < 20) begin
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         tick();
         cnt++;
         if (aw_now) begin
            awvalid = 1'b0;
            aw_done = 1;
         end
         if (w_now) begin
            wvalid = 1'b0;
            w_done = 1;
         end
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      cnt     = 0;
      while (!bvalid && cnt < 20) begin
         tick();
         cnt++;
      end
      checks++;
      if (bvalid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL write_bvalid addr=%h got bvalid=%b expected 1", addr, bvalid);
         resp = 2'b11;
      end else begin
         resp = bresp;
      end
      tick();
      bready = 1'b0;
   endtask

   // Full read; RREADY is raised only after the data has been sampled.
   task automatic do_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
      int cnt;
      cnt     = 0;
      araddr  = addr;
      arvalid = 1'b1;
      rready  = 1'b0;
      while (!arready && cnt < 20) begin
         tick();
         cnt++;
      end
      tick();
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL read_rvalid addr=%h got rvalid=%b expected 1", addr, rvalid);
         data = 32'hxxxxxxxx;
         resp = 2'b11;
      end else begin
         data = rdata;
         resp = rresp;
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   // Outputs while reset is held, then READYs one cycle after release.
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL reset_flags got %b expected 00000",
                  {awready, wready, arready, bvalid, rvalid});
      end
      checks++;
      if (regs_out !== '0) begin
         failures++;
         $display("[TB] FAIL reset_regs got %h expected 0", regs_out);
      end
      checks++;
      if ({rdata, bresp, rresp} !== 36'h0) begin
         failures++;
         $display("[TB] FAIL reset_resp got rdata=%h bresp=%b rresp=%b expected 0/00/00",
                  rdata, bresp, rresp);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL reset_release_ready got %b expected 111",
                  {awready, wready, arready});
      end
   endtask

   // AW and W on the same edge: BVALID the cycle after, register updated.
   task automatic test_same_cycle_write();
      awaddr  = 8'h04;
      wdata   = 32'hDEADBEEF;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      checks++;
      if (bvalid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL same_cycle_pre_bvalid got %b expected 0", bvalid);
      end
      tick();
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      model[1] = 32'hDEADBEEF;
      checks++;
      if ({bvalid, bresp} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL same_cycle_bresp got bvalid=%b bresp=%b expected 1/00",
                  bvalid, bresp);
      end
      checks++;
      if (regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL same_cycle_regs got %h expected %h", regs_out, packed_model());
      end
      checks++;
      if ({awready, wready} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL same_cycle_ready_in_resp got %b expected 00", {awready, wready});
      end
      tick();
      checks++;
      if ({bvalid, awready, wready} !== 3'b011) begin
         failures++;
         $display("[TB] FAIL same_cycle_done got bvalid/aw/w=%b expected 011",
                  {bvalid, awready, wready});
      end
      bready = 1'b0;
   endtask

   // W three cycles ahead of AW: commit only on the AW edge, single BVALID.
   task automatic test_w_before_aw();
      wdata   = 32'h12345678;
      wstrb   = 4'hF;
      wvalid  = 1'b1;
      awvalid = 1'b0;
      bready  = 1'b1;
      tick();
      wvalid = 1'b0;
      checks++;
      if ({wready, awready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL w_first_ready got w/aw=%b expected 01", {wready, awready});
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({bvalid, wready} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL w_first_wait%0d got bvalid/wready=%b expected 00",
                     i, {bvalid, wready});
         end
      end
      checks++;
      if (regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL w_first_early_commit got %h expected %h", regs_out, packed_model());
      end
      awaddr  = 8'h08;
      awvalid = 1'b1;
      tick();
      awvalid  = 1'b0;
      model[2] = 32'h12345678;
      checks++;
      if ({bvalid, bresp} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL w_first_bresp got bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
      end
      checks++;
      if (regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL w_first_regs got %h expected %h", regs_out, packed_model());
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (bvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL w_first_single_bvalid%0d got %b expected 0", i, bvalid);
         end
      end
      bready = 1'b0;
   endtask

   // Read of reg1 held off by RREADY low for four cycles.
   task automatic test_read_stall();
      araddr  = 8'h04;
      arvalid = 1'b1;
      rready  = 1'b0;
      tick();
      arvalid = 1'b0;
      checks++;
      if ({rvalid, arready, rresp} !== 4'b1000 || rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("[TB] FAIL read_first got rvalid/arready/rresp=%b rdata=%h expected 1000/deadbeef",
                  {rvalid, arready, rresp}, rdata);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({rvalid, arready} !== 2'b10 || rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL read_hold%0d got rvalid/arready=%b rdata=%h expected 10/deadbeef",
                     i, {rvalid, arready}, rdata);
         end
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      checks++;
      if ({rvalid, arready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL read_release got rvalid/arready=%b expected 01", {rvalid, arready});
      end
   endtask

   // Out-of-range writes/reads, the last in-range register, unaligned addresses.
   task automatic test_out_of_range();
      logic [1:0]  resp;
      logic [31:0] data;
      do_write(8'h40, 32'hCAFEF00D, 4'hF, resp);
      checks++;
      if (resp !== 2'b10 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL oor_write_40 got bresp=%b regs=%h expected 10 regs=%h",
                  resp, regs_out, packed_model());
      end
      do_read(8'h40, data, resp);
      checks++;
      if (resp !== 2'b10 || data !== 32'h0) begin
         failures++;
         $display("[TB] FAIL oor_read_40 got rresp=%b rdata=%h expected 10/00000000", resp, data);
      end
      do_write(8'h20, 32'h99999999, 4'hF, resp);
      checks++;
      if (resp !== 2'b10 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL oor_write_20 got bresp=%b regs=%h expected 10 regs=%h",
                  resp, regs_out, packed_model());
      end
      do_write(8'h1C, 32'h0BADF00D, 4'hF, resp);
      model[7] = 32'h0BADF00D;
      checks++;
      if (resp !== 2'b00 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL last_reg_write got bresp=%b regs=%h expected 00 regs=%h",
                  resp, regs_out, packed_model());
      end
      do_read(8'h1C, data, resp);
      checks++;
      if (resp !== 2'b00 || data !== 32'h0BADF00D) begin
         failures++;
         $display("[TB] FAIL last_reg_read got rresp=%b rdata=%h expected 00/0badf00d", resp, data);
      end
      do_read(8'h0B, data, resp);
      checks++;
      if (resp !== 2'b00 || data !== 32'h12345678) begin
         failures++;
         $display("[TB] FAIL unaligned_read got rresp=%b rdata=%h expected 00/12345678", resp, data);
      end
      do_write(8'h0F, 32'h33333333, 4'hF, resp);
      model[3] = 32'h33333333;
      checks++;
      if (resp !== 2'b00 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL unaligned_write got bresp=%b regs=%h expected 00 regs=%h",
                  resp, regs_out, packed_model());
      end
   endtask

   // Byte strobes: honoured only when the strobe build is selected.
   task automatic test_wstrb();
      logic [1:0]  resp;
      logic [31:0] expect0;
      do_write(8'h00, 32'hFFFFFFFF, 4'hF, resp);
      model[0] = 32'hFFFFFFFF;
      do_write(8'h00, 32'h00000000, 4'b0101, resp);
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
      expect0 = 32'hFF00FF00;
`else
      expect0 = 32'h00000000;
`endif
      model[0] = expect0;
      checks++;
      if (resp !== 2'b00 || regs_out[31:0] !== expect0) begin
         failures++;
         $display("[TB] FAIL wstrb_0101 got bresp=%b reg0=%h expected 00/%h",
                  resp, regs_out[31:0], expect0);
      end
      do_write(8'h00, 32'h11223344, 4'b0000, resp);
`ifdef S_AXI_LITE_REGBANK_WSTRB_EN
      expect0 = 32'hFF00FF00;
`else
      expect0 = 32'h11223344;
`endif
      model[0] = expect0;
      checks++;
      if (resp !== 2'b00 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL wstrb_zero got bresp=%b reg0=%h expected 00/%h",
                  resp, regs_out[31:0], expect0);
      end
   endtask

   // Read and write to the same register on the same edge: read sees old value.
   task automatic test_concurrent();
      logic [1:0]  resp;
      logic [31:0] data;
      awaddr  = 8'h0C;
      wdata   = 32'h44444444;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      araddr  = 8'h0C;
      arvalid = 1'b1;
      rready  = 1'b0;
      tick();
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      arvalid  = 1'b0;
      model[3] = 32'h44444444;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h33333333) begin
         failures++;
         $display("[TB] FAIL concurrent_old_value got rvalid=%b rdata=%h expected 1/33333333",
                  rvalid, rdata);
      end
      checks++;
      if (bvalid !== 1'b1 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL concurrent_commit got bvalid=%b regs=%h expected 1 regs=%h",
                  bvalid, regs_out, packed_model());
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      bready = 1'b0;
      checks++;
      if ({bvalid, rvalid} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL concurrent_done got bvalid/rvalid=%b expected 00", {bvalid, rvalid});
      end
      do_read(8'h0C, data, resp);
      checks++;
      if (resp !== 2'b00 || data !== 32'h44444444) begin
         failures++;
         $display("[TB] FAIL concurrent_readback got rresp=%b rdata=%h expected 00/44444444",
                  resp, data);
      end
   endtask

   // Reset while a response is pending, reset aborting a half write, recovery.
   task automatic test_reset_mid();
      logic [1:0] resp;
      awaddr  = 8'h10;
      wdata   = 32'h55555555;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b0;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      tick();
      checks++;
      if (bvalid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_pending_bvalid got %b expected 1", bvalid);
      end
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
      checks++;
      if ({bvalid, awready, wready, arready} !== 4'b0000 || regs_out !== '0) begin
         failures++;
         $display("[TB] FAIL mid_reset_async got bvalid/aw/w/ar=%b regs=%h expected 0000/0",
                  {bvalid, awready, wready, arready}, regs_out);
      end
      tick();
      #2 rst = 1'b0;
      tick();
      checks++;
      if ({awready, wready, arready, bvalid} !== 4'b1110) begin
         failures++;
         $display("[TB] FAIL mid_release got aw/w/ar/bvalid=%b expected 1110",
                  {awready, wready, arready, bvalid});
      end
      wdata  = 32'h66666666;
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      awaddr  = 8'h14;
      awvalid = 1'b1;
      bready  = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      checks++;
      if (bvalid !== 1'b0 || regs_out !== '0) begin
         failures++;
         $display("[TB] FAIL abort_half_write got bvalid=%b regs=%h expected 0/0", bvalid, regs_out);
      end
      wdata  = 32'h77777777;
      wvalid = 1'b1;
      tick();
      wvalid   = 1'b0;
      model[5] = 32'h77777777;
      checks++;
      if (bvalid !== 1'b1 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL abort_then_complete got bvalid=%b regs=%h expected 1 regs=%h",
                  bvalid, regs_out, packed_model());
      end
      tick();
      bready = 1'b0;
      do_write(8'h04, 32'hA5A5A5A5, 4'hF, resp);
      model[1] = 32'hA5A5A5A5;
      checks++;
      if (resp !== 2'b00 || regs_out !== packed_model()) begin
         failures++;
         $display("[TB] FAIL post_reset_write got bresp=%b regs=%h expected 00 regs=%h",
                  resp, regs_out, packed_model());
      end
   endtask

   // Test sequence.
   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
      rst     = 1'b1;
      awaddr  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      araddr  = '0;
      arvalid = 1'b0;
      rready  = 1'b0;

      $display("[TB] starting s_axi_lite_regbank tests");
      test_reset();
      test_same_cycle_write();
      test_w_before_aw();
      test_read_stall();
      test_out_of_range();
      test_wstrb();
      test_concurrent();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
